// File: rtl/ndata_packer_if.sv
// Stream interfaces for the packer: a single-element stream and an N-lane beat
// stream, both with per-element keep, shared last and valid/ready handshake.
interface data_i #(
   parameter type data_t = logic [31:0]
);
   data_t data;
   logic  keep;
   logic  last;
   logic  valid;
   logic  ready;

   modport m (output data, keep, last, valid, input ready);
   modport s (input data, keep, last, valid, output ready);
endinterface

interface ndata_i #(
   parameter type data_t       = logic [31:0],
   parameter int  NUM_ELEMENTS = 4
);
   data_t [NUM_ELEMENTS-1:0] data;
   logic  [NUM_ELEMENTS-1:0] keep;
   logic                     last;
   logic                     valid;
   logic                     ready;

   modport m (output data, keep, last, valid, input ready);
   modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_packer.sv
// Packs a serial element stream into NUM_ELEMENTS-lane beats; lanes fill in
// order, and last (or a full beat) flushes the accumulator to the output register.
module ndata_packer #(
   parameter type data_t       = logic [31:0],
   parameter int  NUM_ELEMENTS = 4
) (
   input  logic clk,
   input  logic rst,
   data_i.s     in,
   ndata_i.m    out
);
   localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

   logic [IDX_W-1:0]         idx_reg;
   data_t [NUM_ELEMENTS-1:0] lane_data;
   logic  [NUM_ELEMENTS-1:0] lane_keep;
   logic                     free;
   logic                     completes;
   logic                     accept;
   logic                     load;

   assign free      = !out.valid || out.ready;
   assign completes = in.last || (in.keep && idx_reg == IDX_W'(NUM_ELEMENTS - 1));
   // Partial fills never depend on the output register, so a stalled beat
   // only blocks the element that would close the next one.
   assign in.ready  = !rst && (free || !completes);
   assign accept    = in.valid && in.ready;
   assign load      = accept && completes;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_lane
         data_t acc_data_reg;
         logic  acc_keep_reg;
         logic  hit;

         assign hit = in.keep && (idx_reg == IDX_W'(gi));

         always_ff @(posedge clk) begin
            if (rst || load) begin
               acc_data_reg <= '0;
               acc_keep_reg <= 1'b0;
            end else if (accept && hit) begin
               acc_data_reg <= in.data;
               acc_keep_reg <= 1'b1;
            end
         end

         // The completing element is merged straight into its lane on load.
         assign lane_data[gi] = hit ? in.data : acc_data_reg;
         assign lane_keep[gi] = hit | acc_keep_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || load) begin
         idx_reg <= '0;
      end else if (accept && in.keep) begin
         idx_reg <= idx_reg + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out.valid <= 1'b0;
         out.data  <= '0;
         out.keep  <= '0;
         out.last  <= 1'b0;
      end else if (load) begin
         out.valid <= 1'b1;
         out.data  <= lane_data;
         out.keep  <= lane_keep;
         out.last  <= in.last;
      end else if (out.ready) begin
         out.valid <= 1'b0;
      end
   end
endmodule
